// File: rtl/pipe_pkg.sv
// Shared definitions for the pipe_stage_skid pipeline stage:
// occupancy state encoding and stall-counter sizing.
package pipe_pkg;

    // Occupancy of the stage: nothing, main register only, main + skid.
    // The encoding 2'b11 is never produced and decodes as empty.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_BUSY  = 2'b01,
        ST_FULL  = 2'b10
    } state_e;

    localparam int                     STALL_CNT_W   = 16;
    localparam logic [STALL_CNT_W-1:0] STALL_CNT_MAX = '1;

endpackage

// File: rtl/pipe_stage_skid_reg_en.sv
// reg_en: enabled register with synchronous active-high reset to a
// parameterised value. Serves as the storage primitive for pipe_stage_skid.
module reg_en #(
    parameter int               WIDTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    // Load d when enabled, otherwise hold; reset wins over enable.
    always_ff @(posedge clk) begin
        // NOTE: sequential state is written with <= so every flop samples
        // pre-edge values, independent of block evaluation order.
        if (rst) begin
            // NOTE: data registers are reset here on purpose: RESET_VAL is an
            // architected, observable payload value, not a don't-care.
            q <= RESET_VAL;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/pipe_stage_skid.sv
// pipe_stage_skid: valid/ready pipeline stage with a one-entry skid buffer.
// in_ready comes straight from a flop, so a downstream stall never creates a
// combinational ready path upstream. Supports flush and a reset payload value.
// Optional build macro PIPE_STAGE_SKID_STALL_CNT_EN adds a saturating
// stall_cnt output counting cycles with out_valid=1 and out_ready=0.
module pipe_stage_skid
    import pipe_pkg::*;
#(
    parameter int               WIDTH     = 16,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [WIDTH-1:0]       in_data,
    output logic                   out_valid,
    input  logic                   out_ready,
`ifdef PIPE_STAGE_SKID_STALL_CNT_EN
    output logic [STALL_CNT_W-1:0] stall_cnt,
`endif
    output logic [WIDTH-1:0]       out_data
);

    logic [1:0]       state_q;
    logic [1:0]       state_cur;
    logic [1:0]       state_d;
    logic             in_ready_d;
    logic             main_en;
    logic             skid_en;
    logic [WIDTH-1:0] main_d;
    logic [WIDTH-1:0] skid_d;
    logic [WIDTH-1:0] skid_q;
    logic             in_xfer;
    logic             out_xfer;

    // Illegal encoding 2'b11 behaves as EMPTY, so the stage self-recovers.
    assign state_cur = ((state_q == ST_BUSY) || (state_q == ST_FULL)) ? state_q : ST_EMPTY;
    assign out_valid = (state_cur != ST_EMPTY);
    assign in_xfer   = in_valid & in_ready;
    assign out_xfer  = out_valid & out_ready;

    // Next occupancy and data-register loads; flush overrides everything.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path
        // leaves a signal unassigned, which would otherwise infer a latch.
        state_d = state_cur;
        main_en = 1'b0;
        skid_en = 1'b0;
        main_d  = in_data;
        skid_d  = in_data;
        case (state_cur)
            ST_EMPTY: begin
                if (in_xfer) begin
                    state_d = ST_BUSY;
                    main_en = 1'b1;
                end
            end
            ST_BUSY: begin
                if (in_xfer && !out_xfer) begin
                    state_d = ST_FULL;
                    skid_en = 1'b1;
                end else if (!in_xfer && out_xfer) begin
                    state_d = ST_EMPTY;
                end else if (in_xfer && out_xfer) begin
                    main_en = 1'b1;
                end
            end
            ST_FULL: begin
                // in_ready is low here, so only the drain path applies.
                if (out_xfer) begin
                    state_d = ST_BUSY;
                    main_en = 1'b1;
                    main_d  = skid_q;
                end
            end
            default: state_d = ST_EMPTY;
        endcase
        if (flush) begin
            state_d = ST_EMPTY;
            main_en = 1'b1;
            skid_en = 1'b1;
            main_d  = RESET_VAL;
            skid_d  = RESET_VAL;
        end
    end

    // in_ready is the registered form of "next state is not FULL".
    assign in_ready_d = (state_d != ST_FULL);

    reg_en #(.WIDTH(2), .RESET_VAL(ST_EMPTY)) u_state (
        .clk (clk),
        .rst (rst),
        .en  (1'b1),
        .d   (state_d),
        .q   (state_q)
    );

    reg_en #(.WIDTH(1), .RESET_VAL(1'b1)) u_in_ready (
        .clk (clk),
        .rst (rst),
        .en  (1'b1),
        .d   (in_ready_d),
        .q   (in_ready)
    );

    reg_en #(.WIDTH(WIDTH), .RESET_VAL(RESET_VAL)) u_main (
        .clk (clk),
        .rst (rst),
        .en  (main_en),
        .d   (main_d),
        .q   (out_data)
    );

    reg_en #(.WIDTH(WIDTH), .RESET_VAL(RESET_VAL)) u_skid (
        .clk (clk),
        .rst (rst),
        .en  (skid_en),
        .d   (skid_d),
        .q   (skid_q)
    );

`ifdef PIPE_STAGE_SKID_STALL_CNT_EN
    // Count stalled cycles, saturating; cleared by reset or flush.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            stall_cnt <= '0;
        end else if (out_valid && !out_ready && (stall_cnt != STALL_CNT_MAX)) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end
`endif

endmodule
